// File: rtl/leds_pio_rmw_arbiter_pkg.sv
// Shared definitions for the LED PIO read-modify-write arbiter: register
// width, PIO word address, FSM state encoding and the masked merge helper.
package nios_soc_leds_pkg;

  localparam int         LEDS_W        = 14;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } leds_state_e;

  // Bits with mask=1 take the new value, bits with mask=0 keep the old one.
  function automatic logic [31:0] rmw_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/leds_pio_rmw_arbiter_if.sv
// Avalon-MM bus between the arbiter (master) and the LED PIO slave port.
interface leds_pio_rmw_arbiter_if;

  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata
  );

  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata
  );

endinterface

// File: rtl/leds_pio_rmw_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: searches req starting at index
// ptr, wrapping modulo NUM_REQ. Reusable for any shared PIO.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_p;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    idx_p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_p = PTR_W'(idx);
      if (req[idx_p]) begin
        grant = idx_p;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leds_pio_rmw_arbiter.sv
// Shares the LED PIO output register among NUM_REQ requesters. Each granted
// request performs a read-modify-write on PIO address 0 so a requester only
// changes the LED bits it owns. All bus outputs are registered.
module leds_pio_rmw_arbiter
  import nios_soc_leds_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = LEDS_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  leds_pio_rmw_arbiter_if.master    pio
);

  localparam int PTR_W = $clog2(NUM_REQ);

  leds_state_e         state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    grant_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mask_q;
  logic [DATA_W-1:0]   rd_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                busy_q;
  logic                cs_q;
  logic                write_n_q;
  logic [31:0]         writedata_q;

  logic [PTR_W-1:0]    arb_grant;
  logic                arb_valid;

  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [DATA_W-1:0]   mask_arr [NUM_REQ];

  // Unflatten the per-requester data and mask slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    assign mask_arr[gi] = req_mask[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Transaction FSM: IDLE -> READ -> WRITE -> ACK, outputs registered per state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rd_q        <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      writedata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (arb_valid) begin
            grant_q   <= arb_grant;
            data_q    <= data_arr[arb_grant];
            mask_q    <= mask_arr[arb_grant];
            cs_q      <= 1'b1;
            write_n_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= READ;
          end
        end
        READ: begin
          // Zero-wait-state slave: readdata is valid during this cycle, so the
          // merged word is registered here and presented for the WRITE cycle.
          rd_q        <= pio.pio_readdata[DATA_W-1:0];
          writedata_q <= rmw_merge(32'(pio.pio_readdata[DATA_W-1:0]),
                                   32'(data_q), 32'(mask_q));
          write_n_q   <= 1'b0;
          state_q     <= WRITE;
        end
        WRITE: begin
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          ack_q     <= NUM_REQ'(1) << grant_q;
          state_q   <= ACK;
        end
        ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack                = ack_q;
  assign busy               = busy_q;
  assign pio.pio_address    = PIO_ADDR_DATA;
  assign pio.pio_chipselect = cs_q;
  assign pio.pio_write_n    = write_n_q;
  assign pio.pio_writedata  = writedata_q;

  // The upper PIO read bits carry nothing; rd_q is kept as the captured
  // pre-write LED value for debug visibility.
  logic unused_bits;
  assign unused_bits = ^{pio.pio_readdata[31:DATA_W], rd_q};

endmodule

// File: tb/tb_leds_pio_rmw_arbiter.sv
// Randomized bench for leds_pio_rmw_arbiter with a transaction-level model
// of the round-robin pointer and the LED register contents.
module tb_leds_pio_rmw_arbiter;

  localparam int N = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N*W-1:0] req_mask = '0;
  logic [N-1:0]   ack;
  logic           busy;

  leds_pio_rmw_arbiter_if pio_bus();

  leds_pio_rmw_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .req_mask (req_mask),
    .ack      (ack),
    .busy     (busy),
    .pio      (pio_bus.master)
  );

  always #5 clk = ~clk;

  // PIO slave model: one 14-bit register, zero-wait read, plus a CPU preset port.
  logic [W-1:0] led_reg = '0;
  logic         cpu_wr  = 1'b0;
  logic [W-1:0] cpu_val = '0;
  assign pio_bus.pio_readdata = 32'(led_reg);
  always @(posedge clk) begin
    if (cpu_wr)
      led_reg <= cpu_val;
    else if (pio_bus.pio_chipselect && !pio_bus.pio_write_n && pio_bus.pio_address == 2'd0)
      led_reg <= pio_bus.pio_writedata[W-1:0];
  end

  int n_compared = 0;
  int n_mismatch = 0;

  // Reference model state.
  int       m_ptr = 0;
  logic [W-1:0] m_led = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] led_after(input logic [W-1:0] old_v,
                                              input logic [W-1:0] d,
                                              input logic [W-1:0] m);
    return (old_v & ~m) | (d & m);
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic preset_led(input logic [W-1:0] v);
    cpu_val = v;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_wr  = 1'b0;
    m_led   = v;
  endtask

  // One full transaction, called at a negedge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] r, input bit drop_early);
    int           w;
    logic [W-1:0] d, m, e;
    logic [N-1:0] ea;
    w  = pick(r, m_ptr);
    d  = req_data[w*W +: W];
    m  = req_mask[w*W +: W];
    e  = led_after(m_led, d, m);
    ea = '0;
    ea[w] = 1'b1;
    req = r;
    @(negedge clk);  // READ
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_cs", 32'(pio_bus.pio_chipselect), 32'd1);
    check("rd_wn", 32'(pio_bus.pio_write_n), 32'd1);
    check("rd_ack", 32'(ack), 32'd0);
    if (drop_early) req = '0;
    req_data = rand_vec();  // must not matter once latched
    req_mask = rand_vec();
    @(negedge clk);  // WRITE
    check("wr_cs", 32'(pio_bus.pio_chipselect), 32'd1);
    check("wr_wn", 32'(pio_bus.pio_write_n), 32'd0);
    check("wr_addr", 32'(pio_bus.pio_address), 32'd0);
    check("wr_data", pio_bus.pio_writedata, 32'(e));
    check("wr_ack", 32'(ack), 32'd0);
    @(negedge clk);  // ACK
    check("ack_onehot", 32'(ack), 32'(ea));
    check("ack_cs", 32'(pio_bus.pio_chipselect), 32'd0);
    check("ack_wn", 32'(pio_bus.pio_write_n), 32'd1);
    check("ack_busy", 32'(busy), 32'd1);
    check("led_val", 32'(led_reg), 32'(e));
    req = '0;
    @(negedge clk);  // IDLE
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_cs", 32'(pio_bus.pio_chipselect), 32'd0);
    m_led = e;
    m_ptr = (w + 1) % N;
    $display("txn req=%b grant=%0d data=%04h mask=%04h led=%04h", r, w, d, m, e);
  endtask

  initial begin
    int           w;
    logic [W-1:0] e;
    logic [N-1:0] ea;
    logic [N-1:0] r;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cs", 32'(pio_bus.pio_chipselect), 32'd0);
    check("rst_wn", 32'(pio_bus.pio_write_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_wd", pio_bus.pio_writedata, 32'd0);
    check("rst_addr", 32'(pio_bus.pio_address), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: basic masked write from requester 0
    preset_led(14'h0000);
    req_data = rand_vec();
    req_mask = rand_vec();
    req_data[0*W +: W] = 14'h3FFF;
    req_mask[0*W +: W] = 14'h00FF;
    run_txn(4'b0001, 1'b0);
    check("dir_led_00ff", 32'(led_reg), 32'h00FF);

    // Directed: requester 1 preserves low byte
    preset_led(14'h00FF);
    req_data[1*W +: W] = 14'h2A00;
    req_mask[1*W +: W] = 14'h3F00;
    run_txn(4'b0010, 1'b0);
    check("dir_led_2aff", 32'(led_reg), 32'h2AFF);

    // Directed: mask zero leaves LEDs untouched
    preset_led(14'h1234);
    req_data[2*W +: W] = 14'h3FFF;
    req_mask[2*W +: W] = 14'h0000;
    run_txn(4'b0100, 1'b0);
    check("dir_led_1234", 32'(led_reg), 32'h1234);

    // Directed: req2 dropped in the READ cycle
    req_data = rand_vec();
    req_mask = rand_vec();
    run_txn(4'b0100, 1'b1);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) preset_led(W'($urandom));
      req_data = rand_vec();
      req_mask = rand_vec();
      if ($urandom_range(0, 5) == 0) req_mask = '0;
      r = N'($urandom_range(1, (1 << N) - 1));
      run_txn(r, 1'($urandom_range(0, 1)));
    end

    // All requesters held continuously for 8 transactions
    req_data = rand_vec();
    req_mask = rand_vec();
    req = '1;
    w = 0;
    e = '0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      case (n % 4)
        1: begin
          check("cont_rd_cs", 32'(pio_bus.pio_chipselect), 32'd1);
          check("cont_ack0", 32'(ack), 32'd0);
        end
        2: begin
          w = pick(req, m_ptr);
          e = led_after(m_led, req_data[w*W +: W], req_mask[w*W +: W]);
          check("cont_wd", pio_bus.pio_writedata, 32'(e));
          check("cont_ack0", 32'(ack), 32'd0);
        end
        3: begin
          ea = '0;
          ea[w] = 1'b1;
          check("cont_ack", 32'(ack), 32'(ea));
          m_led = e;
          m_ptr = (w + 1) % N;
          $display("txn req=%b grant=%0d (continuous) led=%04h", req, w, e);
        end
        default: begin
          check("cont_idle_busy", 32'(busy), 32'd0);
          check("cont_ack0", 32'(ack), 32'd0);
        end
      endcase
    end
    req = '0;
    @(negedge clk);
    check("cont_end_busy", 32'(busy), 32'd0);

    // Move the pointer away from 0, then reset during a WRITE
    req_data = rand_vec();
    req_mask = rand_vec();
    run_txn(4'b0100, 1'b0);  // ptr now 3
    preset_led(W'($urandom));
    req_data = rand_vec();
    req_mask = rand_vec();
    req = 4'b0100;
    @(negedge clk);  // READ
    @(negedge clk);  // WRITE
    check("prerst_wn", 32'(pio_bus.pio_write_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs", 32'(pio_bus.pio_chipselect), 32'd0);
    check("arst_wn", 32'(pio_bus.pio_write_n), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge clk);
    check("arst_ack2", 32'(ack), 32'd0);
    check("arst_led", 32'(led_reg), 32'(m_led));
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    $display("txn reset during WRITE, write abandoned");

    // Pointer is back at 0: with req 1 and 3 pending, 1 must win
    req_data = rand_vec();
    req_mask = rand_vec();
    run_txn(4'b1010, 1'b0);
    // Requester 3 alone is served
    req_data = rand_vec();
    req_mask = rand_vec();
    run_txn(4'b1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
